// File: rtl/battleship_pkg.sv
// Shared types for the battleship board store: cell encoding, game ops, fire results, arbiter states.
package battleship_pkg;

  localparam int BOARD_CELLS = 100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    MISS  = 2'd2,
    HIT   = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FIRE  = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    RES_INVALID = 2'd0,
    RES_MISS    = 2'd1,
    RES_HIT     = 2'd2,
    RES_REPEAT  = 2'd3
  } res_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  // Value a FIRE leaves behind on a cell that was EMPTY or SHIP.
  function automatic cell_t fire_mark(input cell_t c);
    return (c == SHIP) ? HIT : MISS;
  endfunction

endpackage

// File: rtl/board_ram.sv
// Single-port CELLS x 2-bit board store; read data registered one cycle after the access, read-before-write.
// Out-of-range addresses read EMPTY and ignore writes; reset clears every cell.
module board_ram
  import battleship_pkg::*;
#(
  parameter int CELLS = BOARD_CELLS,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  cell_t         wdata_i,
  output cell_t         rdata_o
);

  localparam logic [AW-1:0] CELLS_W = AW'(CELLS);

  cell_t mem_q [CELLS];
  cell_t rdata_q;
  logic  in_range;

  assign in_range = (addr_i < CELLS_W);
  assign rdata_o  = rdata_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < CELLS; i++) begin
        mem_q[i] <= EMPTY;
      end
      rdata_q <= EMPTY;
    end else begin
      rdata_q <= in_range ? mem_q[addr_i] : EMPTY;
      if (we_i && in_range) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board store shared between 1-cycle render reads (priority) and req/ack game ops; starved game ops force a slot.
// Define ARB_HIT_COUNT_EN to build the hit_count/all_sunk tally; otherwise both outputs are tied low.
module board_mem_arbiter
  import battleship_pkg::*;
#(
  parameter int CELLS      = BOARD_CELLS,
  parameter int AW         = 7,
  parameter int MAX_WAIT   = 64,
  parameter int SHIP_CELLS = 17
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          bright_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [1:0]    rd_data_o,
  output logic          rd_stale_o,
  input  logic          g_req_i,
  input  logic [1:0]    g_op_i,
  input  logic [AW-1:0] g_addr_i,
  input  logic [1:0]    g_wdata_i,
  output logic          g_ack_o,
  output logic [1:0]    g_rdata_o,
  output logic [1:0]    g_result_o,
  output logic          busy_o,
  output logic [AW-1:0] hit_count_o,
  output logic          all_sunk_o
);

  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] CELLS_W  = AW'(CELLS);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  arb_state_t    state_q;
  op_t           op_q;
  logic [AW-1:0] addr_q;
  cell_t         wdata_q;
  cell_t         cell_q;
  logic [WW-1:0] wait_q;
  logic          gnt_game_q;
  logic          rnd_gnt_q;
  logic          rd_stale_q;
  cell_t         rd_hold_q;
  logic          g_ack_q;
  logic          ack_fresh_q;
  cell_t         g_rdata_q;
  res_t          g_result_q;
  logic          busy_q;

  cell_t         ram_rdata;
  cell_t         ram_wdata;
  cell_t         cell_now;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          addr_ok;
  logic          game_pend;
  logic          game_gnt;
  logic          rnd_gnt;

  // The RAM read lands a cycle after the grant, so a FIRE inspects its cell at
  // the start of ACC2 and keeps a copy for any further ACC2 cycles lost to render.
  always_comb begin
    cell_now  = gnt_game_q ? ram_rdata : cell_q;
    addr_ok   = (addr_q < CELLS_W);
    game_pend = 1'b0;
    if (state_q == ST_ACC1) begin
      game_pend = addr_ok;
    end else if (state_q == ST_ACC2) begin
      game_pend = (cell_now == EMPTY) || (cell_now == SHIP);
    end
    game_gnt  = game_pend && (!rd_en_i || (wait_q == WAIT_MAX));
    rnd_gnt   = rd_en_i && !game_gnt;
    ram_addr  = game_gnt ? addr_q : rd_addr_i;
    ram_we    = game_gnt && ((state_q == ST_ACC2) || (op_q == OP_WRITE));
    ram_wdata = (state_q == ST_ACC2) ? fire_mark(cell_now) : wdata_q;
  end

  board_ram #(
    .CELLS (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= EMPTY;
      cell_q      <= EMPTY;
      wait_q      <= '0;
      gnt_game_q  <= 1'b0;
      rnd_gnt_q   <= 1'b0;
      rd_stale_q  <= 1'b0;
      rd_hold_q   <= EMPTY;
      g_ack_q     <= 1'b0;
      ack_fresh_q <= 1'b0;
      g_rdata_q   <= EMPTY;
      g_result_q  <= RES_INVALID;
      busy_q      <= 1'b0;
    end else begin
      gnt_game_q <= game_gnt;
      rnd_gnt_q  <= rnd_gnt;
      rd_stale_q <= game_gnt && rd_en_i && bright_i;
      g_ack_q    <= 1'b0;
      if (rnd_gnt_q) begin
        rd_hold_q <= ram_rdata;
      end

      if (game_gnt) begin
        wait_q <= '0;
      end else if (game_pend && (wait_q != WAIT_MAX)) begin
        wait_q <= wait_q + WW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (g_req_i) begin
            op_q    <= (g_op_i == 2'b11) ? OP_READ : op_t'(g_op_i);
            addr_q  <= g_addr_i;
            wdata_q <= cell_t'(g_wdata_i);
            busy_q  <= 1'b1;
            state_q <= ST_ACC1;
          end
        end
        ST_ACC1: begin
          if (!addr_ok) begin
            g_rdata_q   <= EMPTY;
            g_result_q  <= RES_INVALID;
            ack_fresh_q <= 1'b0;
            g_ack_q     <= 1'b1;
            state_q     <= ST_ACK;
          end else if (game_gnt) begin
            if (op_q == OP_FIRE) begin
              state_q <= ST_ACC2;
            end else begin
              g_result_q  <= RES_INVALID;
              ack_fresh_q <= 1'b1;
              g_ack_q     <= 1'b1;
              state_q     <= ST_ACK;
            end
          end
        end
        ST_ACC2: begin
          if (gnt_game_q) begin
            cell_q <= cell_now;
          end
          if ((cell_now == MISS) || (cell_now == HIT)) begin
            g_rdata_q   <= cell_now;
            g_result_q  <= RES_REPEAT;
            ack_fresh_q <= 1'b0;
            g_ack_q     <= 1'b1;
            state_q     <= ST_ACK;
          end else if (game_gnt) begin
            g_rdata_q   <= cell_now;
            g_result_q  <= (cell_now == SHIP) ? RES_HIT : RES_MISS;
            ack_fresh_q <= 1'b0;
            g_ack_q     <= 1'b1;
            state_q     <= ST_ACK;
          end
        end
        default: begin
          // READ/WRITE data only arrives from the RAM in this cycle; park it for the hold.
          if (ack_fresh_q) begin
            g_rdata_q <= ram_rdata;
          end
          ack_fresh_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_data_o  = rnd_gnt_q ? ram_rdata : rd_hold_q;
  assign rd_stale_o = rd_stale_q;
  assign g_ack_o    = g_ack_q;
  assign g_rdata_o  = ack_fresh_q ? ram_rdata : g_rdata_q;
  assign g_result_o = g_result_q;
  assign busy_o     = busy_q;

`ifdef ARB_HIT_COUNT_EN
  logic [AW-1:0] hit_q;
  logic [AW-1:0] hit_d;
  logic          all_sunk_q;

  always_comb begin
    hit_d = hit_q;
    if ((state_q == ST_ACC2) && game_gnt && (cell_now == SHIP)) begin
      hit_d = hit_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_q      <= '0;
      all_sunk_q <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      all_sunk_q <= all_sunk_q | (hit_d == AW'(SHIP_CELLS));
    end
  end

  assign hit_count_o = hit_q;
  assign all_sunk_o  = all_sunk_q;
`else
  assign hit_count_o = '0;
  assign all_sunk_o  = 1'b0;
`endif

endmodule
